// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, zero-register constant and queue entry type for the write-back arbiter
package wb_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam logic [ADDR_WIDTH-1:0] WB_ZERO_REG = '0;
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// wb_queue: power-of-2 FIFO of write-back entries; a kill clears valid on every slot with a matching address
module wb_queue import wb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  wb_entry_t                 push_entry,
  input  logic                      pop,
  input  logic                      kill,
  input  logic [ADDR_WIDTH-1:0]     kill_addr,
  output wb_entry_t                 head,
  output wb_entry_t                 entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0]  head_ptr,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PW = $clog2(DEPTH);
  wb_entry_t mem_q [DEPTH];
  wb_entry_t mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0] cnt_q, cnt_d;
  // killed slots stay occupied so they still pop in order, just without writing
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      mem_d[i].valid = mem_q[i].valid && !(kill && mem_q[i].addr == kill_addr);
    end
    if (push) begin
      mem_d[wr_q] = push_entry;
      mem_d[wr_q].valid = push_entry.valid && !(kill && push_entry.addr == kill_addr);
    end
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    wr_d = push ? wr_q + PW'(1) : wr_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  assign head = mem_q[rd_q];
  assign entries = mem_q;
  assign head_ptr = rd_q;
  assign count = cnt_q;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline and long-latency write-backs onto one register-file write port.
// WB_BYPASS_EN builds the read-address bypass; otherwise fwd*_hit/fwd*_data are tied to 0.
module wb_arbiter import wb_pkg::*; #(
  parameter int DATA_WIDTH = wb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
  parameter int LQ_DEPTH   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pipe_wen,
  input  logic [ADDR_WIDTH-1:0]       pipe_waddr,
  input  logic [DATA_WIDTH-1:0]       pipe_wdata,
  input  logic                        lu_valid,
  output logic                        lu_ready,
  input  logic [ADDR_WIDTH-1:0]       lu_waddr,
  input  logic [DATA_WIDTH-1:0]       lu_wdata,
  output logic                        rf_wen,
  output logic [ADDR_WIDTH-1:0]       rf_waddr,
  output logic [DATA_WIDTH-1:0]       rf_wdata,
  input  logic [ADDR_WIDTH-1:0]       raddr1,
  input  logic [ADDR_WIDTH-1:0]       raddr2,
  output logic                        fwd1_hit,
  output logic                        fwd2_hit,
  output logic [DATA_WIDTH-1:0]       fwd1_data,
  output logic [DATA_WIDTH-1:0]       fwd2_data,
  output logic [$clog2(LQ_DEPTH):0]   q_count
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  logic pipe_eff, push, pop, head_wr;
  wb_entry_t head;
  wb_entry_t entries [LQ_DEPTH];
  logic [PW-1:0] head_ptr;
  logic rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  assign pipe_eff = pipe_wen && pipe_waddr != WB_ZERO_REG;
  assign lu_ready = !rst && q_count < CW'(LQ_DEPTH);
  assign push = lu_valid && lu_ready && lu_waddr != WB_ZERO_REG;
  assign pop = !pipe_eff && q_count != '0;
  assign head_wr = pop && head.valid;
  wb_queue #(.DEPTH(LQ_DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_entry('{valid: 1'b1, addr: lu_waddr, data: lu_wdata}),
    .pop(pop),
    .kill(pipe_eff),
    .kill_addr(pipe_waddr),
    .head(head),
    .entries(entries),
    .head_ptr(head_ptr),
    .count(q_count)
  );
  always_comb begin
    rf_wen_d = pipe_eff || head_wr;
    rf_waddr_d = pipe_eff ? pipe_waddr : head_wr ? head.addr : rf_waddr_q;
    rf_wdata_d = pipe_eff ? pipe_wdata : head_wr ? head.data : rf_wdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end
  assign rf_wen = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
`ifdef WB_BYPASS_EN
  // walk from head to tail so the youngest matching queue entry overrides the rf_* hit
  function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] ra);
    wb_entry_t e;
    lookup = '0;
    if (ra != WB_ZERO_REG) begin
      if (rf_wen_q && rf_waddr_q == ra) lookup = {1'b1, rf_wdata_q};
      for (int i = 0; i < LQ_DEPTH; i++) begin
        e = entries[head_ptr + PW'(i)];
        if (CW'(i) < q_count && e.valid && e.addr == ra) lookup = {1'b1, e.data};
      end
    end
  endfunction
  always_comb begin
    {fwd1_hit, fwd1_data} = lookup(raddr1);
    {fwd2_hit, fwd2_data} = lookup(raddr2);
  end
`else
  logic unused_bypass;
  always_comb begin
    unused_bypass = ^{raddr1, raddr2, head_ptr};
    for (int i = 0; i < LQ_DEPTH; i++) unused_bypass = unused_bypass ^ (^entries[i]);
  end
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table-driven directed vectors plus reset sequences for wb_arbiter
module tb_wb_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic pipe_wen = 1'b0, lu_valid = 1'b0;
  logic [4:0] pipe_waddr = '0, lu_waddr = '0, raddr1 = '0, raddr2 = '0;
  logic [31:0] pipe_wdata = '0, lu_wdata = '0;
  logic lu_ready, rf_wen, fwd1_hit, fwd2_hit;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata, fwd1_data, fwd2_data;
  logic [1:0] q_count;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic pw; logic [4:0] pa; logic [31:0] pd;
    logic lv; logic [4:0] la; logic [31:0] ld;
    logic [4:0] r1, r2;
    logic ew; logic [4:0] ea; logic [31:0] ed;
    logic [1:0] eq; logic er;
    logic h1; logic [31:0] d1; logic h2; logic [31:0] d2;
  } vec_t;
  vec_t vecs[$];
  int checks = 0, fails = 0;
  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .q_count(q_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic add(input bit pw, input logic [4:0] pa, input logic [31:0] pd,
                     input bit lv, input logic [4:0] la, input logic [31:0] ld,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input bit ew, input logic [4:0] ea, input logic [31:0] ed,
                     input logic [1:0] eq, input bit er,
                     input bit h1, input logic [31:0] d1, input bit h2, input logic [31:0] d2);
    vec_t v;
    v = '{pw, pa, pd, lv, la, ld, r1, r2, ew, ea, ed, eq, er, h1, d1, h2, d2};
    vecs.push_back(v);
  endtask
  task automatic drive(input bit pw, input logic [4:0] pa, input logic [31:0] pd,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2);
    pipe_wen = pw; pipe_waddr = pa; pipe_wdata = pd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    raddr1 = r1; raddr2 = r2;
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  initial begin
    // reset state
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      #1;
      chk($sformatf("reset%0d rf_wen", c), rf_wen, 0);
      chk($sformatf("reset%0d rf_waddr", c), rf_waddr, 0);
      chk($sformatf("reset%0d rf_wdata", c), rf_wdata, 0);
      chk($sformatf("reset%0d q_count", c), q_count, 0);
      chk($sformatf("reset%0d lu_ready", c), lu_ready, 0);
      chk($sformatf("reset%0d fwd1_hit", c), fwd1_hit, 0);
      chk($sformatf("reset%0d fwd1_data", c), fwd1_data, 0);
    end
    rst = 1'b0;
    // pipeline write, bypass from rf_*
    add(1, 5, 'h1234, 0, 0, 0,     5, 0,   0, 5'd0, 'h0,    0, 1, 0, 0,      0, 0);
    add(0, 0, 0,      0, 0, 0,     5, 6,   1, 5,  'h1234,   0, 1, 1, 'h1234, 0, 0);
    // long-latency write with pipeline idle
    add(0, 0, 0,      1, 8, 'hAA,  8, 0,   0, 5,  'h1234,   0, 1, 0, 0,      0, 0);
    add(0, 0, 0,      0, 0, 0,     8, 0,   0, 5,  'h1234,   1, 1, 1, 'hAA,   0, 0);
    add(0, 0, 0,      0, 0, 0,     8, 0,   1, 8,  'hAA,     0, 1, 1, 'hAA,   0, 0);
    // starvation: queue fills, then drains in order
    add(1, 1, 'h101,  1, 9, 'h900, 9, 0,   0, 8,  'hAA,     0, 1, 0, 0,      0, 0);
    add(1, 2, 'h202,  1, 10,'hA00, 9, 10,  1, 1,  'h101,    1, 1, 1, 'h900,  0, 0);
    add(1, 3, 'h303,  1, 11,'hB00, 10, 2,  1, 2,  'h202,    2, 0, 1, 'hA00,  1, 'h202);
    add(1, 4, 'h404,  0, 0, 0,     3, 0,   1, 3,  'h303,    2, 0, 1, 'h303,  0, 0);
    add(0, 0, 0,      0, 0, 0,     9, 0,   1, 4,  'h404,    2, 0, 1, 'h900,  0, 0);
    add(0, 0, 0,      0, 0, 0,     9, 10,  1, 9,  'h900,    1, 1, 1, 'h900,  1, 'hA00);
    add(0, 0, 0,      0, 0, 0,     0, 10,  1, 10, 'hA00,    0, 1, 0, 0,      1, 'hA00);
    // kill of a queued entry
    add(0, 0, 0,      1, 7, 'h11,  0, 0,   0, 10, 'hA00,    0, 1, 0, 0,      0, 0);
    add(1, 7, 'h22,   0, 0, 0,     7, 0,   0, 10, 'hA00,    1, 1, 1, 'h11,   0, 0);
    add(0, 0, 0,      0, 0, 0,     7, 0,   1, 7,  'h22,     1, 1, 1, 'h22,   0, 0);
    add(0, 0, 0,      0, 0, 0,     7, 0,   0, 7,  'h22,     0, 1, 0, 0,      0, 0);
    // writes to r0 are dropped, r0 never bypasses
    add(0, 0, 0,      1, 0, 'h55,  0, 7,   0, 7,  'h22,     0, 1, 0, 0,      0, 0);
    add(1, 0, 'h66,   0, 0, 0,     0, 7,   0, 7,  'h22,     0, 1, 0, 0,      0, 0);
    add(0, 0, 0,      0, 0, 0,     0, 7,   0, 7,  'h22,     0, 1, 0, 0,      0, 0);
    // same-cycle push is killed by a younger pipeline write
    add(1, 12,'hC1,   1, 12,'hC0,  0, 0,   0, 7,  'h22,     0, 1, 0, 0,      0, 0);
    add(0, 0, 0,      0, 0, 0,     12, 0,  1, 12, 'hC1,     1, 1, 1, 'hC1,   0, 0);
    add(0, 0, 0,      0, 0, 0,     12, 0,  0, 12, 'hC1,     0, 1, 0, 0,      0, 0);
    // youngest of two queued entries to the same register wins the bypass
    add(1, 1, 'h1,    1, 13,'hD1,  0, 0,   0, 12, 'hC1,     0, 1, 0, 0,      0, 0);
    add(1, 2, 'h2,    1, 13,'hD2,  0, 0,   1, 1,  'h1,      1, 1, 0, 0,      0, 0);
    add(1, 3, 'h3,    0, 0, 0,     13, 0,  1, 2,  'h2,      2, 0, 1, 'hD2,   0, 0);
    add(0, 0, 0,      0, 0, 0,     13, 0,  1, 3,  'h3,      2, 0, 1, 'hD2,   0, 0);
    add(0, 0, 0,      0, 0, 0,     13, 0,  1, 13, 'hD1,     1, 1, 1, 'hD2,   0, 0);
    add(0, 0, 0,      0, 0, 0,     13, 0,  1, 13, 'hD2,     0, 1, 1, 'hD2,   0, 0);
    add(0, 0, 0,      0, 0, 0,     13, 0,  0, 13, 'hD2,     0, 1, 0, 0,      0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pw, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld, vecs[i].r1, vecs[i].r2);
      #1;
      chk($sformatf("v%0d rf_wen", i), rf_wen, vecs[i].ew);
      chk($sformatf("v%0d rf_waddr", i), rf_waddr, vecs[i].ea);
      chk($sformatf("v%0d rf_wdata", i), rf_wdata, vecs[i].ed);
      chk($sformatf("v%0d q_count", i), q_count, vecs[i].eq);
      chk($sformatf("v%0d lu_ready", i), lu_ready, vecs[i].er);
      chk($sformatf("v%0d fwd1_hit", i), fwd1_hit, BYP ? vecs[i].h1 : 1'b0);
      chk($sformatf("v%0d fwd1_data", i), fwd1_data, BYP ? vecs[i].d1 : 32'h0);
      chk($sformatf("v%0d fwd2_hit", i), fwd2_hit, BYP ? vecs[i].h2 : 1'b0);
      chk($sformatf("v%0d fwd2_data", i), fwd2_data, BYP ? vecs[i].d2 : 32'h0);
      next_cycle();
    end
    // reset with a full queue discards it without issuing writes
    drive(1, 1, 'h1, 1, 20, 'h20, 0, 0);
    next_cycle();
    drive(1, 1, 'h2, 1, 21, 'h21, 0, 0);
    next_cycle();
    drive(1, 2, 'h3, 0, 0, 0, 0, 0);
    #1;
    chk("prerst q_count", q_count, 2);
    chk("prerst lu_ready", lu_ready, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 20, 21);
    rst = 1'b1;
    #1;
    chk("inrst lu_ready", lu_ready, 0);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("postrst%0d rf_wen", c), rf_wen, 0);
      chk($sformatf("postrst%0d q_count", c), q_count, 0);
      chk($sformatf("postrst%0d lu_ready", c), lu_ready, 1);
      chk($sformatf("postrst%0d fwd1_hit", c), fwd1_hit, 0);
      next_cycle();
    end
    chk("postrst rf_waddr", rf_waddr, 0);
    chk("postrst rf_wdata", rf_wdata, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sitting directly upstream of the 32x32 register file. Merges the in-order pipeline write-back (one write per cycle, never stalled) with results returned by the long-latency unit (loads, divider) over a valid/ready handshake. Drives the register file's single write port (`wen`/`waddr`/`wdata`) from registered outputs and exposes bypass data for the two read addresses.

## Interface
- `DATA_WIDTH`, 32, register data width
- `ADDR_WIDTH`, 5, register address width
- `LQ_DEPTH`, 2, long-latency queue entries (power of 2, ≥2)

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `pipe_wen`  in  1  pipeline write-back request
- `pipe_waddr`  in  ADDR_WIDTH  pipeline destination register
- `pipe_wdata`  in  DATA_WIDTH  pipeline result
- `lu_valid`  in  1  long-latency result valid
- `lu_ready`  out  1  queue can accept a result
- `lu_waddr`  in  ADDR_WIDTH  long-latency destination register
- `lu_wdata`  in  DATA_WIDTH  long-latency result
- `rf_wen`  out  1  register file write enable
- `rf_waddr`  out  ADDR_WIDTH  register file write address
- `rf_wdata`  out  DATA_WIDTH  register file write data
- `raddr1`, `raddr2`  in  ADDR_WIDTH  decode-stage read addresses
- `fwd1_hit`, `fwd2_hit`  out  1  bypass valid per port
- `fwd1_data`, `fwd2_data`  out  DATA_WIDTH  bypass value per port
- `q_count`  out  $clog2(LQ_DEPTH)+1  occupied queue entries

## Operation
- **Pipeline writes.**
  - A pipeline write is effective when `pipe_wen` is high and `pipe_waddr != 0`.
  - An effective pipeline write always wins the write port.
- **Long-latency handshake.**
  - Transfer occurs when `lu_valid && lu_ready`.
  - `lu_ready = !rst && (q_count < LQ_DEPTH)`. It depends on registered state only.
  - A transfer with `lu_waddr == 0` is accepted and discarded, not enqueued.
  - Other transfers push `{valid=1, addr, data}` at the tail.
- **Drain.**
  - When no effective pipeline write occurs and the queue is non-empty, pop the head.
  - If the head is valid, it writes. If it was killed, it pops silently with `rf_wen` 0 that cycle.
- **Kill.**
  - Pipeline writes are architecturally younger than every queued entry, including one pushed in the same cycle.
  - An effective pipeline write clears the valid bit of every queued or same-cycle-pushed entry with a matching address.
- **Output.** Every cycle, `rf_*` register the selected write. If there is none, `rf_wen` is 0 and `rf_waddr`/`rf_wdata` hold their values.
- **Bypass** (per port, combinational):
  - Priority 1: the youngest valid queue entry matching `raddr`.
  - Priority 2: `rf_*` when `rf_wen` is high and `rf_waddr == raddr`.
  - Otherwise `hit` is 0 and `data` is 0.
  - `raddr == 0` never hits.
- **Simultaneous push and pop** in one cycle: both happen and `q_count` is unchanged.

## Timing
- **Reset values:** `rf_wen` 0, `rf_waddr` 0, `rf_wdata` 0, `q_count` 0, `lu_ready` 0, `fwd*_hit` 0, `fwd*_data` 0.
- **Reset mid-operation:** all queue contents are discarded with no writes issued. `lu_ready` rises the first cycle after `rst` falls.
- **Pipeline latency:** `pipe_wen` in cycle N gives `rf_wen` in cycle N+1. The register file commits at the edge ending N+1.
- **Long-latency latency:** transfer in cycle N enters the queue at the N/N+1 edge. The earliest pop is in N+1, so `rf_wen` is seen at N+2.
- **Starvation:** back-to-back pipeline writes stall the drain indefinitely. `lu_ready` drops once the queue is full.
- **Queue pointers** wrap modulo `LQ_DEPTH`. Full and empty are distinguished by `q_count`.

## Configuration
- `WB_BYPASS_EN` defined: bypass logic is built as described above.
- `WB_BYPASS_EN` undefined: `fwd1_hit`, `fwd2_hit`, `fwd1_data` and `fwd2_data` are tied to 0, and the queue address-compare logic used for bypass is removed.
- Kill logic is present in both builds.

## Structure
- **Package `wb_pkg`:**
  - `DATA_WIDTH`/`ADDR_WIDTH` defaults
  - typedef `wb_entry_t` (`valid`, `addr`, `data`)
  - constant `WB_ZERO_REG = 0`
- **Sub-module `wb_queue`:**
  - parameterised FIFO of `wb_entry_t`, with push/pop and per-entry kill-by-address
  - exports its entry array for bypass lookup
- **`wb_arbiter`** holds the arbitration, output registers and bypass mux.

## Test plan
- Reset, then `pipe_wen=1` with `waddr=5`, `wdata=0x1234` in cycle 1 → `rf_wen=1`, `rf_waddr=5`, `rf_wdata=0x1234` in cycle 2; `fwd1_hit=1` for `raddr1=5` in cycle 2.
- Long-latency result (`waddr=8`, `wdata=0xAA`) with the pipeline idle → `q_count=1` next cycle, `rf_wen` at transfer+2.
- Continuous pipeline writes to r1..r4 while two long-latency results arrive → `lu_ready=0` with `q_count=2`; both long-latency writes appear in order after the pipeline goes idle.
- Queue holds r7=0x11, then a pipeline write r7=0x22 → only 0x22 is written, the killed entry pops with `rf_wen=0`, and `fwd1_data=0x22` while `rf_wen` is high.
- `lu_waddr=0` transfer, then `pipe_waddr=0` write → no `rf_wen`, `q_count` stays 0, and `raddr1=0` gives `fwd1_hit=0`.
- Assert `rst` with `q_count=2` → no `rf_wen` afterwards, `q_count=0`, and `lu_ready=0` during reset, 1 after.
